// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and elaboration-time helpers for the BCD converter
// Contents: state_t (IDLE/SHIFT), bcd_digit_t, pow10() and lz_mask().
package bcd_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int MAX_DIGITS = 10;

    // 10^n in 64 bits; the loop bound is fixed so it stays a constant function.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            if (k < n) r = r * 64'd10;
        end
        return r;
    endfunction

    // Leading-zero blank mask over the lowest n digits. Bit i is set when
    // digits i..n-1 are all zero. Bit 0 is always clear so zero shows "0".
    function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [4*MAX_DIGITS-1:0] bcd,
                                                      input int n);
        logic [MAX_DIGITS-1:0] m;
        logic                  zero;
        m    = '0;
        zero = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < n) begin
                zero = zero && (bcd[4*i +: 4] == 4'd0);
                m[i] = zero;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction (add 3 when digit >= 5)
// Ports: digit (4-bit BCD digit in), adjusted (corrected digit out).
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - iterative binary-to-BCD converter, one input bit per clock
// Ports: clk_in, rst_n_in (sync active-low); bin_in/valid_in/ready_out request side;
//        dec_out, blank_out, overflow_out qualified by the one-cycle valid_out pulse.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 5
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [4*DIGITS-1:0]   dec_out,
    output logic [DIGITS-1:0]     blank_out,
    output logic                  overflow_out,
    output logic                  valid_out
);

    localparam int                 SW        = 4 * DIGITS;
    localparam int                 CW        = $clog2(BIN_WIDTH + 1);
    localparam logic [63:0]        DEC_MAX   = pow10(DIGITS) - 64'd1;
    localparam logic [DIGITS-1:0]  BLANK_RST = {DIGITS{1'b1}} << 1;
    localparam logic [SW-1:0]      NINES     = {DIGITS{4'h9}};

    state_t                state_q, state_d;
    logic [BIN_WIDTH-1:0]  shreg_q, shreg_d;
    logic [SW-1:0]         scratch_q, scratch_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [SW-1:0]         dec_d;
    logic [DIGITS-1:0]     blank_d;
    logic                  overflow_d;
    logic                  valid_d;
    logic [SW-1:0]         adj;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (scratch_q[4*g +: 4]),
            .adjusted (adj[4*g +: 4])
        );
    end

    assign ready_out = (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        dec_d      = dec_out;
        blank_d    = blank_out;
        overflow_d = overflow_out;
        valid_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    shreg_d   = bin_in;
                    scratch_d = '0;
                    cnt_d     = CW'(BIN_WIDTH);
                    ovf_d     = (64'(bin_in) > DEC_MAX);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Bits carried out of the top digit are dropped; overflow is
                // already known from the accept-time compare.
                {scratch_d, shreg_d} = {adj, shreg_q} << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d    = IDLE;
                    valid_d    = 1'b1;
                    overflow_d = ovf_q;
                    dec_d      = ovf_q ? NINES : scratch_d;
                    blank_d    = ovf_q ? '0
                                       : DIGITS'(lz_mask((4*MAX_DIGITS)'(scratch_d), DIGITS));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            scratch_q    <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            dec_out      <= '0;
            blank_out    <= BLANK_RST;
            overflow_out <= 1'b0;
            valid_out    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            scratch_q    <= scratch_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            dec_out      <= dec_d;
            blank_out    <= blank_d;
            overflow_out <= overflow_d;
            valid_out    <= valid_d;
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - scoreboard bench for bin_to_bcd_seq (16/5 and 8/2 builds)
module tb_bin_to_bcd_seq;

    typedef struct {
        logic [39:0] dec;
        logic [9:0]  blank;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] bin_a;
    logic        valid_a, ready_a, ovf_a, vout_a;
    logic [19:0] dec_a;
    logic [4:0]  blank_a;
    logic [7:0]  bin_b;
    logic        valid_b, ready_b, ovf_b, vout_b;
    logic [7:0]  dec_b;
    logic [1:0]  blank_b;

    exp_t qa[$];
    exp_t qb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   vcnt_a     = 0;
    int   vcnt_b     = 0;

    bin_to_bcd_seq #(.BIN_WIDTH(16), .DIGITS(5)) u_a (
        .clk_in(clk), .rst_n_in(rst_n), .bin_in(bin_a), .valid_in(valid_a),
        .ready_out(ready_a), .dec_out(dec_a), .blank_out(blank_a),
        .overflow_out(ovf_a), .valid_out(vout_a)
    );

    bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(2)) u_b (
        .clk_in(clk), .rst_n_in(rst_n), .bin_in(bin_b), .valid_in(valid_b),
        .ready_out(ready_b), .dec_out(dec_b), .blank_out(blank_b),
        .overflow_out(ovf_b), .valid_out(vout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits by repeated division, saturating above 10^digits-1.
    function automatic exp_t model(input longint unsigned v, input int digits);
        exp_t            e;
        longint unsigned mx, t;
        bit              zero;
        mx = 1;
        for (int k = 0; k < digits; k++) mx = mx * 10;
        mx = mx - 1;
        e.dec = '0; e.blank = '0; e.ovf = 1'b0;
        if (v > mx) begin
            e.ovf = 1'b1;
            for (int k = 0; k < digits; k++) e.dec[4*k +: 4] = 4'h9;
        end else begin
            t = v;
            for (int k = 0; k < digits; k++) begin
                e.dec[4*k +: 4] = 4'(t % 10);
                t = t / 10;
            end
            zero = 1'b1;
            for (int i = digits - 1; i >= 1; i--) begin
                zero = zero && (e.dec[4*i +: 4] == 4'd0);
                e.blank[i] = zero;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && vout_a) begin
            exp_t e;
            vcnt_a++;
            check("a_result_expected", 64'(qa.size() != 0), 64'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                check("a_dec", 64'(dec_a), 64'(e.dec[19:0]));
                check("a_blank", 64'(blank_a), 64'(e.blank[4:0]));
                check("a_ovf", 64'(ovf_a), 64'(e.ovf));
            end
        end
        if (rst_n && vout_b) begin
            exp_t e;
            vcnt_b++;
            check("b_result_expected", 64'(qb.size() != 0), 64'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                check("b_dec", 64'(dec_b), 64'(e.dec[7:0]));
                check("b_blank", 64'(blank_b), 64'(e.blank[1:0]));
                check("b_ovf", 64'(ovf_b), 64'(e.ovf));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic start_a(input logic [15:0] v);
        check("a_ready_at_request", 64'(ready_a), 64'd1);
        bin_a = v; valid_a = 1'b1;
        qa.push_back(model(64'(v), 5));
        @(posedge clk);
        @(negedge clk);
        valid_a = 1'b0;
        bin_a = 16'($urandom);
    endtask

    task automatic start_b(input logic [7:0] v);
        check("b_ready_at_request", 64'(ready_b), 64'd1);
        bin_b = v; valid_b = 1'b1;
        qb.push_back(model(64'(v), 2));
        @(posedge clk);
        @(negedge clk);
        valid_b = 1'b0;
        bin_b = 8'($urandom);
    endtask

    task automatic wait_a(input int lat, input string tag);
        int cyc = 0;
        while (!vout_a && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(lat));
        check({tag, "_ready_with_valid"}, 64'(ready_a), 64'd1);
    endtask

    task automatic wait_b(input int lat, input string tag);
        int cyc = 0;
        while (!vout_b && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int base;
        rst_n = 1'b0;
        valid_a = 1'b0; bin_a = '0;
        valid_b = 1'b0; bin_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dec", 64'(dec_a), 64'h0);
        check("rst_blank", 64'(blank_a), 64'b11110);
        check("rst_ovf", 64'(ovf_a), 64'd0);
        check("rst_valid", 64'(vout_a), 64'd0);
        check("rst_ready", 64'(ready_a), 64'd1);
        check("rst_b_blank", 64'(blank_b), 64'b10);
        rst_n = 1'b1;
        @(negedge clk);

        start_a(16'd0);
        wait_a(16, "zero");
        check("zero_dec", 64'(dec_a), 64'h0);
        check("zero_blank", 64'(blank_a), 64'b11110);
        @(negedge clk);

        start_a(16'd199);
        wait_a(16, "v199");
        check("v199_dec", 64'(dec_a), 64'h00199);
        check("v199_blank", 64'(blank_a), 64'b11000);
        start_a(16'd65535);
        wait_a(16, "v65535");
        check("v65535_dec", 64'(dec_a), 64'h65535);
        check("v65535_blank", 64'(blank_a), 64'b0);
        repeat (3) @(negedge clk);
        check("hold_dec", 64'(dec_a), 64'h65535);
        check("hold_valid_low", 64'(vout_a), 64'd0);

        start_a(16'd1234);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        void'(qa.pop_back());
        check("abort_valid", 64'(vout_a), 64'd0);
        check("abort_dec", 64'(dec_a), 64'h0);
        check("abort_blank", 64'(blank_a), 64'b11110);
        check("abort_ready", 64'(ready_a), 64'd1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (vout_a) seen++;
        end
        check("abort_no_valid", 64'(seen), 64'd0);
        start_a(16'd1234);
        wait_a(16, "v1234");
        check("v1234_dec", 64'(dec_a), 64'h01234);
        check("v1234_blank", 64'(blank_a), 64'b10000);
        @(negedge clk);

        base = vcnt_a;
        for (int i = 0; i < 102; i++) begin
            bin_a = 16'($urandom_range(0, 65535));
            valid_a = 1'b1;
            if (i % 17 == 0) qa.push_back(model(64'(bin_a), 5));
            @(negedge clk);
        end
        valid_a = 1'b0;
        repeat (20) @(negedge clk);
        check("stream_result_count", 64'(vcnt_a - base), 64'd6);

        start_b(8'd200);
        wait_b(8, "b200");
        check("b200_dec", 64'(dec_b), 64'h99);
        check("b200_ovf", 64'(ovf_b), 64'd1);
        check("b200_blank", 64'(blank_b), 64'b00);
        start_b(8'd42);
        wait_b(8, "b42");
        check("b42_dec", 64'(dec_b), 64'h42);
        check("b42_ovf", 64'(ovf_b), 64'd0);
        @(negedge clk);
        start_b(8'd5);
        wait_b(8, "b5");
        check("b5_dec", 64'(dec_b), 64'h05);
        check("b5_blank", 64'(blank_b), 64'b10);
        repeat (3) @(negedge clk);

        check("a_queue_drained", 64'(qa.size()), 64'd0);
        check("b_queue_drained", 64'(qb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Parametrised, iterative (double-dabble) binary-to-BCD converter for score, timer and order-count readouts feeding the seven-segment and on-screen digit renderers. It generalises the fixed 8-bit, 3-digit converter to any input width and digit count. It adds a valid/ready handshake, saturation on overflow and a leading-zero blanking mask. It trades latency for area: one input bit is processed per clock, with no wide comparator chains.

Parameters:
BIN_WIDTH, 16, width of the unsigned binary input; legal range 4..32.
DIGITS, 5, number of BCD output digits; legal range 1..10.

Ports:
clk_in  input  1  system clock; all logic is on the rising edge.
rst_n_in  input  1  synchronous reset, active-low.
bin_in  input  BIN_WIDTH  unsigned value to convert; sampled only on the accept edge.
valid_in  input  1  request to convert bin_in.
ready_out  output  1  high when the block can accept a request (state IDLE).
dec_out  output  4*DIGITS  BCD result; digit i is dec_out[4i+3:4i], digit 0 is the ones digit.
blank_out  output  DIGITS  leading-zero mask; bit i high means digit i should be blanked.
overflow_out  output  1  high when the last accepted value exceeded 10^DIGITS-1.
valid_out  output  1  one-cycle pulse marking that dec_out, blank_out and overflow_out have just been updated.

Behaviour:
- Reset: sampled only on a clk_in edge with rst_n_in low; asynchronous changes are ignored.
- Reset values: state=IDLE, dec_out=0, blank_out={DIGITS-1{1},0}, overflow_out=0, valid_out=0. ready_out is 1 from the first edge after reset.
- Reset mid-conversion aborts the conversion. No valid_out is produced, and outputs take their reset values.
- While rst_n_in is low, valid_in is ignored.
- States:
  - IDLE: ready_out=1. An accept happens when valid_in && ready_out at an edge. On accept: latch bin_in into the shift register, clear the BCD scratch, set bit counter=BIN_WIDTH, latch ovf = (bin_in > 10^DIGITS-1), go to SHIFT.
  - SHIFT: ready_out=0. Each edge: add 3 to every scratch digit that is >= 5, then shift {scratch, shreg} left by 1 and decrement the counter.
  - SHIFT, final iteration (counter==1): register the results into dec_out, blank_out and overflow_out, set valid_out=1 and return to IDLE.
- Latency: valid_out is high in the cycle that begins BIN_WIDTH edges after the accept edge (16 cycles by default).
- Throughput: ready_out is high in the same cycle valid_out is high, so back-to-back accepts give one result per BIN_WIDTH+1 cycles.
- Hold: outputs hold their last value between conversions. valid_out is high for exactly one cycle per accept.
- Scratch width: the scratch register is 4*DIGITS bits. Bits shifted beyond the top digit are discarded.
- Overflow: when ovf is set, dec_out is saturated to all digits = 9, overflow_out=1 and blank_out=0. Otherwise overflow_out=0.
- Blanking: blank_out[i]=1 iff i>0 and digits i..DIGITS-1 are all zero. Digit 0 is never blanked, so zero displays as "0".
- Accumulated values: with DIGITS large enough for BIN_WIDTH, no overflow is possible and ovf is constant 0.
- Handshake changes: changes in bin_in or valid_in outside IDLE have no effect.
- Arithmetic: all of it is unsigned. 10^DIGITS-1 is computed at elaboration in 64 bits.

Decomposition:
- Package bcd_pkg:
  - function pow10(n), returning 64-bit;
  - localparam-friendly typedef state_t {IDLE, SHIFT};
  - typedef bcd_digit_t = logic [3:0].
- Sub-module bcd_digit_adj: combinational, 4-bit in/out, outputs in+3 when in>=5, otherwise in. The parent instantiates it DIGITS times in a generate loop.
- A separate leading-zero function in bcd_pkg computes the blank mask.

Test Plan:
- Defaults; reset, then bin_in=0 accepted -> valid_out 16 cycles later; dec_out=0x00000, blank_out=5'b11110, overflow_out=0.
- bin_in=199 -> dec_out=0x00199, blank_out=5'b11000. Then bin_in=65535 presented in the valid_out cycle -> accepted immediately; 16 cycles later dec_out=0x65535, blank_out=0.
- BIN_WIDTH=8, DIGITS=2; bin_in=200 -> dec_out=0x99, overflow_out=1, blank_out=0. Then bin_in=42 -> 0x42, overflow_out=0.
- Defaults; accept 1234, drop rst_n_in low at cycle 5 for one edge -> no valid_out, dec_out=0, ready_out=1. Re-request 1234 -> 0x01234, blank_out=5'b10000.
- valid_in held high continuously with bin_in changing every cycle -> exactly one valid_out per 17 cycles. Each result matches the bin_in value sampled on its accept edge. Random values are checked against a reference model.
